// File: rtl/iccm_dump_pkg.sv
// Shared types and constants for the ICCM UART read-back dumper.
package iccm_dump_pkg;

    // 1 start bit + 8 data bits + 1 stop bit.
    localparam int FrameBits    = 10;
    // A 32-bit memory word goes out as four bytes, least-significant first.
    localparam int BytesPerWord = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        DONE
    } dump_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for a single byte per handshake. Holds the bit-period
// divisor and bit counters. Accepts the next byte in the last cycle of the
// current stop bit, so frames can run back-to-back with no idle gap.
module uart_tx_byte
    import iccm_dump_pkg::*;
#(
    parameter int DivW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [DivW-1:0] clks_per_bit,
    input  logic            byte_valid,
    output logic            byte_ready,
    input  logic [7:0]      byte_data,
    output logic            tx,
    output logic            frame_done
);

    localparam logic [3:0] StopIdx     = 4'(FrameBits - 1);
    localparam logic [3:0] LastDataIdx = 4'(FrameBits - 2);

    logic            active;
    logic [3:0]      bit_cnt;
    logic [DivW-1:0] div_cnt;
    logic [DivW-1:0] div_last;
    logic [7:0]      shreg;
    logic            bit_end;

    // Bit-boundary detection; a divisor of 0 behaves as 1 cycle per bit.
    always_comb begin
        div_last   = (clks_per_bit == '0) ? '0 : clks_per_bit - DivW'(1);
        bit_end    = active && (div_cnt == div_last);
        frame_done = bit_end && (bit_cnt == StopIdx);
        byte_ready = !active || frame_done;
    end

    // Frame sequencer: start bit on accept, then data LSB first, then stop.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx      <= 1'b1;
            active  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shreg   <= '0;
        end else if (byte_valid && byte_ready) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
            shreg   <= byte_data;
            tx      <= 1'b0;
        end else if (frame_done) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            tx      <= 1'b1;
        end else if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LastDataIdx) begin
                tx <= 1'b1;
            end else begin
                tx    <= shreg[0];
                shreg <= {1'b0, shreg[7:1]};
            end
        end else if (active) begin
            div_cnt <= div_cnt + DivW'(1);
        end
    end

endmodule

// File: rtl/iccm_uart_dumper.sv
// Reads a contiguous range of ICCM words through the req/rvalid port and
// streams each word out of the UART, byte 0 (bits 7:0) first.
module iccm_uart_dumper
    import iccm_dump_pkg::*;
#(
    parameter int AddrW = 12,
    parameter int DataW = 32,   // fixed at 32: four bytes per word
    parameter int DivW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [AddrW-1:0] base_addr_i,
    input  logic [AddrW:0]   word_count_i,
    input  logic [DivW-1:0]  clks_per_bit_i,
    output logic             req_o,
    output logic [AddrW-1:0] addr_o,
    input  logic [DataW-1:0] rdata_i,
    input  logic             rvalid_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] LastByte = 2'(BytesPerWord - 1);

    dump_state_e      state;
    logic [AddrW:0]   remaining;
    logic [1:0]       byte_idx;
    logic [DataW-1:0] shift_word;
    logic [DivW-1:0]  cpb_q;

    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             frame_done;
    logic             word_take;

    // Byte feed to the transmitter: byte 0 comes straight from rdata_i so its
    // start bit lands in the cycle after rvalid_i; later bytes are queued on
    // frame_done so the next start bit follows the stop bit directly.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = shift_word[7:0];
        word_take = (state == WAIT) && rvalid_i && tx_ready;
        if (word_take) begin
            tx_valid = 1'b1;
            tx_data  = rdata_i[7:0];
        end else if ((state == SEND) && frame_done && (byte_idx != LastByte)) begin
            tx_valid = 1'b1;
        end
    end

    // Dump sequencer with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            req_o      <= 1'b0;
            addr_o     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            remaining  <= '0;
            byte_idx   <= '0;
            shift_word <= '0;
            cpb_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        addr_o    <= base_addr_i;
                        remaining <= word_count_i;
                        cpb_q     <= clks_per_bit_i;
                        byte_idx  <= '0;
                        busy_o    <= 1'b1;
                        if (word_count_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= REQ;
                            req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    req_o <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (word_take) begin
                        // Byte 0 is already in the transmitter; keep bytes 1..3.
                        shift_word <= rdata_i >> 8;
                        byte_idx   <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (frame_done) begin
                        if (byte_idx == LastByte) begin
                            addr_o    <= addr_o + AddrW'(1);
                            remaining <= remaining - (AddrW+1)'(1);
                            if (remaining == (AddrW+1)'(1)) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= REQ;
                                req_o <= 1'b1;
                            end
                        end else begin
                            byte_idx   <= byte_idx + 2'd1;
                            shift_word <= shift_word >> 8;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    req_o  <= 1'b0;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .DivW (DivW)
    ) u_tx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clks_per_bit (cpb_q),
        .byte_valid   (tx_valid),
        .byte_ready   (tx_ready),
        .byte_data    (tx_data),
        .tx           (tx_o),
        .frame_done   (frame_done)
    );

endmodule
